// File: rtl/ysyx_24100005_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_mem_arbiter_pkg
//   Shared definitions for the NPC memory-port arbiter: the FSM state
//   encoding, the data word returned on a watchdog timeout, the default
//   watchdog parameters and the latched request record.
// ---------------------------------------------------------------------------
package ysyx_24100005_mem_arbiter_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a requester; the only state that grants
    REQ  = 2'd1,  // presenting the latched request to memory
    RESP = 2'd2   // request accepted by memory, waiting for its response
  } state_e;

  // Read data handed back when the watchdog gives up on the memory.
  localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Cycles allowed from slave request issue to slave response (0 = off).
  localparam int unsigned DEFAULT_TIMEOUT = 256;

  // Watchdog counter width; 2**DEFAULT_CNT_W must exceed DEFAULT_TIMEOUT.
  localparam int unsigned DEFAULT_CNT_W = 9;

  // One request as captured in the grant cycle.
  typedef struct packed {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } req_t;

  // Select the request fields of requester idx (0 = m0, 1 = m1).
  function automatic req_t pick_req(input logic idx, input req_t r0, input req_t r1);
    return idx ? r1 : r0;
  endfunction

endpackage

// File: rtl/ysyx_24100005_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_mem_arbiter_if
//   Request/response bus between a memory requester and a memory responder.
//   One transaction: req_valid/req_ready handshake carrying addr/wen/wdata/
//   wmask, followed later by a single-cycle resp_valid carrying rdata/err.
//
//   Signals
//     req_valid  requester has a transaction
//     req_ready  responder accepts it this cycle
//     addr       byte address
//     wen        1 = write, 0 = read
//     wdata      write data
//     wmask      byte write mask, bits [3:0] meaningful
//     resp_valid one-cycle response pulse
//     rdata      read data, valid with resp_valid
//     err        response is an error (timeout), valid with resp_valid
//
//   Modports
//     master      requester side (IFU / LSU)
//     slave       responder side (the arbiter's upstream ports, a memory)
//     mem_master  requester side without err, for a responder that never
//                 reports errors (the arbiter's downstream memory port)
// ---------------------------------------------------------------------------
interface ysyx_24100005_mem_arbiter_if;

  logic        req_valid;
  logic        req_ready;
  logic [31:0] addr;
  logic        wen;
  logic [31:0] wdata;
  logic [7:0]  wmask;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        err;

  modport master (
    output req_valid, addr, wen, wdata, wmask,
    input  req_ready, resp_valid, rdata, err
  );

  modport slave (
    input  req_valid, addr, wen, wdata, wmask,
    output req_ready, resp_valid, rdata, err
  );

  modport mem_master (
    output req_valid, addr, wen, wdata, wmask,
    input  req_ready, resp_valid, rdata
  );

endinterface

// File: rtl/ysyx_24100005_rr_arb2.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_rr_arb2
//   Purely combinational two-way round-robin picker.
//
//   Ports
//     req[1:0]     request lines, bit i = requester i
//     last_grant   index granted most recently
//     grant_valid  at least one request is present
//     grant_idx    index to grant; on a tie, the one not granted last time
// ---------------------------------------------------------------------------
module ysyx_24100005_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = ~last_grant;
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100005_mem_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_24100005_mem_arbiter
//   Shares the single NPC memory port between instruction fetch (m0) and
//   load/store (m1). One transaction at a time: grant in IDLE, present the
//   latched request in REQ, wait for the response in RESP. Contention is
//   resolved round-robin. A watchdog bounds the time from request issue to
//   response and answers with err=1 / rdata=DEAD_BEEF instead of hanging.
//
//   Parameters
//     TIMEOUT  cycles allowed from request issue to response; 0 disables
//     CNT_W    watchdog counter width, 2**CNT_W > TIMEOUT
//
//   Ports
//     clk  system clock, rising edge
//     rst  asynchronous active-low reset
//     m0   IFU side   (slave modport: arbiter answers the IFU)
//     m1   LSU side   (slave modport: arbiter answers the LSU)
//     s    memory side (mem_master modport: arbiter drives the memory wrapper)
// ---------------------------------------------------------------------------
module ysyx_24100005_mem_arbiter
  import ysyx_24100005_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W   = DEFAULT_CNT_W
) (
  input  logic clk,
  input  logic rst,
  ysyx_24100005_mem_arbiter_if.slave      m0,
  ysyx_24100005_mem_arbiter_if.slave      m1,
  ysyx_24100005_mem_arbiter_if.mem_master s
);

  // Counter value on the last cycle the memory is allowed to take.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam bit               WD_EN    = (TIMEOUT != 0);

  state_e            state_reg;
  state_e            state_next;
  logic              grant_reg;       // requester owning the current transaction
  logic              last_grant_reg;  // requester granted most recently
  req_t              req_reg;         // request fields captured at grant
  logic [CNT_W-1:0]  cnt_reg;         // cycles spent in REQ/RESP

  logic              grant_valid;
  logic              grant_idx;
  logic              complete;
  logic              timeout_hit;
  logic              finish;
  logic [31:0]       resp_data;
  req_t              m0_req;
  req_t              m1_req;

  ysyx_24100005_rr_arb2 u_rr_arb2 (
    .req         ({m1.req_valid, m0.req_valid}),
    .last_grant  (last_grant_reg),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign m0_req = '{addr: m0.addr, wen: m0.wen, wdata: m0.wdata, wmask: m0.wmask};
  assign m1_req = '{addr: m1.addr, wen: m1.wen, wdata: m1.wdata, wmask: m1.wmask};

  // A zero-wait memory may accept and answer in the same REQ cycle; that
  // counts as a completion just like a response seen in RESP. A response
  // arriving in IDLE (e.g. left over from before a reset) matches nothing.
  assign complete = ((state_reg == REQ) && s.req_ready && s.resp_valid) ||
                    ((state_reg == RESP) && s.resp_valid);

  // A genuine completion on the deadline cycle wins over the timeout.
  assign timeout_hit = WD_EN && (state_reg != IDLE) &&
                       (cnt_reg == CNT_LAST) && !complete;

  assign finish    = complete || timeout_hit;
  assign resp_data = timeout_hit ? TIMEOUT_DATA : s.rdata;

  // Memory request fields come straight from the capture registers so they
  // stay stable while the memory stalls the handshake.
  assign s.addr  = req_reg.addr;
  assign s.wen   = req_reg.wen;
  assign s.wdata = req_reg.wdata;
  assign s.wmask = req_reg.wmask;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          state_next = REQ;
        end
      end
      REQ: begin
        if (finish) begin
          state_next = IDLE;
        end else if (s.req_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (finish) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    m0.req_ready  = 1'b0;
    m1.req_ready  = 1'b0;
    m0.resp_valid = 1'b0;
    m1.resp_valid = 1'b0;
    m0.rdata      = '0;
    m1.rdata      = '0;
    m0.err        = 1'b0;
    m1.err        = 1'b0;
    s.req_valid   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (grant_valid) begin
          if (grant_idx) begin
            m1.req_ready = 1'b1;
          end else begin
            m0.req_ready = 1'b1;
          end
        end
      end
      REQ:     s.req_valid = 1'b1;
      default: ;
    endcase

    // Only the owner of the transaction ever sees a response.
    if (finish) begin
      if (grant_reg) begin
        m1.resp_valid = 1'b1;
        m1.rdata      = resp_data;
        m1.err        = timeout_hit;
      end else begin
        m0.resp_valid = 1'b1;
        m0.rdata      = resp_data;
        m0.err        = timeout_hit;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Grant bookkeeping, request capture and watchdog counter
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;  // so that m0 wins the first tie
      req_reg        <= '0;
      cnt_reg        <= '0;
    end else if (state_reg == IDLE) begin
      cnt_reg <= '0;
      if (grant_valid) begin
        grant_reg      <= grant_idx;
        last_grant_reg <= grant_idx;
        req_reg        <= pick_req(grant_idx, m0_req, m1_req);
      end
    end else if (cnt_reg != CNT_MAX) begin
      // Saturate rather than wrap so a disabled watchdog never re-arms.
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: doc/ysyx_24100005_mem_arbiter.md
Name: ysyx_24100005_mem_arbiter

Overview:
- Shares the single NPC memory port between the instruction-fetch requester (m0) and the load/store requester (m1).
- Sequences one transaction at a time: request phase, then response phase.
- Sits between the IFU/LSU and the DPI-backed memory wrapper that calls npcmem_read/npcmem_write.
- Round-robin on contention, with a watchdog timeout that returns an error instead of hanging the core.

Parameters:
- TIMEOUT, 256: cycles allowed from slave request issue to slave response; 0 disables the watchdog.
- CNT_W, 9: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- m0_req_valid / m1_req_valid  in  1  requester has a transaction.
- m0_req_ready / m1_req_ready  out  1  transaction accepted this cycle.
- m0_addr / m1_addr  in  32  byte address.
- m0_wen / m1_wen  in  1  1 = write, 0 = read.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wmask / m1_wmask  in  8  byte write mask; bits [3:0] are used.
- m0_resp_valid / m1_resp_valid  out  1  one-cycle response pulse.
- m0_rdata / m1_rdata  out  32  read data, valid with resp_valid.
- m0_err / m1_err  out  1  response was a timeout, valid with resp_valid.
- s_req_valid  out  1  request to memory.
- s_req_ready  in  1  memory accepts the request.
- s_addr, s_wen, s_wdata, s_wmask  out  32/1/32/8  latched request fields.
- s_resp_valid  in  1  memory response.
- s_rdata  in  32  memory read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, all ready/valid/err outputs 0, s_* data outputs 0.
  - last_grant=1, so m0 wins the first tie.
  - watchdog counter=0.
  - Any in-flight transaction is dropped. A late s_resp_valid arriving in IDLE is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - If exactly one mX_req_valid is high, grant X. If both are high, grant the one that is not last_grant.
  - Grant cycle: mX_req_ready=1 combinationally. Latch addr/wen/wdata/wmask into registers, set grant and last_grant=X, clear the counter, go to REQ.
  - With no request, stay in IDLE.
  - req_ready is never high outside IDLE.
- REQ:
  - s_req_valid=1, s_* driven from the latched registers and stable until the handshake.
  - If s_req_ready=1: go to RESP.
  - If s_req_ready=1 and s_resp_valid=1 in the same cycle: complete the transaction directly (same as RESP completion) and go to IDLE.
- RESP:
  - s_req_valid=0. Wait for s_resp_valid.
  - On s_resp_valid: mG_resp_valid=1, mG_rdata=s_rdata (combinational pass-through), mG_err=0, go to IDLE.
  - Write transactions also complete via s_resp_valid; their rdata is don't-care.
- Watchdog:
  - The counter increments every cycle in REQ or RESP.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no completion that cycle, pulse mG_resp_valid=1, mG_err=1, mG_rdata=32'hDEAD_BEEF, go to IDLE.
  - The counter saturates; it never wraps.
- Outputs to the non-granted requester stay 0.
- Latency:
  - Accept at cycle T.
  - s_req_valid from T+1.
  - Fastest response pulse at T+1 (zero-wait memory); the next accept is possible at T+2.
- Simultaneous events: a completion and the timeout in the same cycle resolve as a normal completion (err=0).

Decomposition:
- Shared header (ysyx_24100005_defs.vh):
  - state localparams IDLE=2'd0, REQ=2'd1, RESP=2'd2.
  - TIMEOUT_DATA=32'hDEAD_BEEF.
  - default TIMEOUT.
- One sub-module, ysyx_24100005_rr_arb2: a purely combinational 2-way round-robin picker.
  - Inputs: req[1:0], last_grant.
  - Outputs: grant_valid, grant_idx.
- The FSM, latches and watchdog stay in the top block.

Test Plan:
1. Reset then m0 read, addr 32'h8000_0000; memory ready in 1 cycle, response 2 cycles later with 32'h0000_0093 -> m0_req_ready at T, s_req_valid T+1, m0_resp_valid with rdata 32'h0000_0093, m0_err=0; m1 outputs stay 0.
2. m0 and m1 both valid for 4 transactions -> grants alternate m0, m1, m0, m1; each req_ready is seen exactly once per accepted transaction.
3. m1 write, addr 32'h8000_0100, wdata 32'h1234_5678, wmask 8'h0F; memory holds s_req_ready=0 for 3 cycles -> s_addr/s_wdata/s_wmask stay constant throughout; m1_resp_valid after s_resp_valid.
4. TIMEOUT=8, memory never responds -> exactly 8 cycles after accept, m0_resp_valid=1, m0_err=1, rdata 32'hDEAD_BEEF; arbiter returns to IDLE and accepts the next request.
5. rst asserted low in RESP, then released; memory then pulses s_resp_valid -> no resp_valid on either requester; the first tie after reset grants m0.
6. Zero-wait memory (s_req_ready and s_resp_valid high in the same cycle) -> response at T+1; back-to-back m0 reads complete every 2 cycles.
